// File: rtl/lpc_block_sequencer_if.sv
// Control and handshake bundle between the LPC block sequencer and its
// sample source / ACF-Durbin-Quantizer-FilterBank datapath.
interface lpc_block_sequencer_if;
  logic       iStart;
  logic       iSampleValid;
  logic       oSampleReady;
  logic       iAcfValid;
  logic       iDurbinDone;
  logic       iQuantValid;
  logic [3:0] iBestPredictor;
  logic       oAcfEnable;
  logic       oAcfReset;
  logic       oDbEnable;
  logic       oDbReset;
  logic       oFifoWrite;
  logic       oFifoRead;
  logic [3:0] oBestPredictor;
  logic       oBestValid;
  logic       oBusy;
  logic       oError;

  // Sequencer side: owns every datapath control.
  modport master (
    input  iStart, iSampleValid, iAcfValid, iDurbinDone, iQuantValid, iBestPredictor,
    output oSampleReady, oAcfEnable, oAcfReset, oDbEnable, oDbReset,
    output oFifoWrite, oFifoRead, oBestPredictor, oBestValid, oBusy, oError
  );

  // Source / datapath side.
  modport slave (
    output iStart, iSampleValid, iAcfValid, iDurbinDone, iQuantValid, iBestPredictor,
    input  oSampleReady, oAcfEnable, oAcfReset, oDbEnable, oDbReset,
    input  oFifoWrite, oFifoRead, oBestPredictor, oBestValid, oBusy, oError
  );
endinterface

// File: rtl/lpc_block_sequencer.sv
// Control FSM for one LPC analysis pass: sample capture, ACF readout, Durbin,
// quantizer drain, filter-bank residual pass, then best-order latch.
module lpc_block_sequencer #(
  parameter int BLOCK_SIZE  = 4096,
  parameter int FIR_LATENCY = 78,
  parameter int TIMEOUT     = 65535,
  parameter int CW          = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  lpc_block_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, WAIT_ACF, ACF_STREAM, DURBIN, QUANT_DRAIN, FILTER, RESULT
  } state_t;

  typedef struct packed {
    logic acf_en;
    logic acf_rst;
    logic db_en;
    logic db_rst;
    logic fifo_rd;
    logic ready;
    logic busy;
  } ctl_t;

  localparam logic [CW-1:0] LP_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LP_CAP_LAST = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0] LP_FLT_LAST = CW'(BLOCK_SIZE + FIR_LATENCY - 1);
  localparam logic [CW-1:0] LP_TO_LAST  = CW'(TIMEOUT - 1);

  // Moore control word for the state being entered; registered on the transition edge.
  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      IDLE:        begin c.acf_rst = 1'b1; c.db_rst = 1'b1; end
      CAPTURE:     begin c.db_rst = 1'b1; c.ready = 1'b1; end
      WAIT_ACF:    c.acf_en = 1'b1;
      ACF_STREAM:  begin c.acf_en = 1'b1; c.db_en = 1'b1; end
      DURBIN:      c.db_en = 1'b1;
      QUANT_DRAIN: c.db_en = 1'b1;
      FILTER:      begin c.db_en = 1'b1; c.fifo_rd = 1'b1; end
      RESULT:      begin c.acf_rst = 1'b1; c.db_rst = 1'b1; end
      default:     begin c.acf_rst = 1'b1; c.db_rst = 1'b1; end
    endcase
    return c;
  endfunction

  state_t        r_state;
  ctl_t          r_ctl;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_best;
  logic          r_best_valid;
  logic          r_error;
  logic          w_cap_take;

  // Capture-phase strobes bypass the registers so each valid sample is taken the same cycle.
  assign w_cap_take = (r_state == CAPTURE) & bus.iSampleValid;

  assign bus.oSampleReady   = r_ctl.ready;
  assign bus.oAcfEnable     = r_ctl.acf_en | w_cap_take;
  assign bus.oAcfReset      = r_ctl.acf_rst;
  assign bus.oDbEnable      = r_ctl.db_en;
  assign bus.oDbReset       = r_ctl.db_rst;
  assign bus.oFifoWrite     = w_cap_take;
  assign bus.oFifoRead      = r_ctl.fifo_rd;
  assign bus.oBestPredictor = r_best;
  assign bus.oBestValid     = r_best_valid;
  assign bus.oBusy          = r_ctl.busy;
  assign bus.oError         = r_error;

  // Sequencer state, shared sample/cycle/wait counter and registered outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= IDLE;
      r_ctl        <= ctl_for(IDLE);
      r_cnt        <= '0;
      r_best       <= 4'd0;
      r_best_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_best_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.iStart) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
            r_state <= CAPTURE;
            r_ctl   <= ctl_for(CAPTURE);
          end
        end
        CAPTURE: begin
          if (bus.iSampleValid) begin
            if (r_cnt == LP_CAP_LAST) begin
              r_cnt   <= '0;
              r_state <= WAIT_ACF;
              r_ctl   <= ctl_for(WAIT_ACF);
            end else begin
              r_cnt <= r_cnt + LP_ONE;
            end
          end
        end
        WAIT_ACF: begin
          if (bus.iAcfValid) begin
            r_state <= ACF_STREAM;
            r_ctl   <= ctl_for(ACF_STREAM);
          end else if (r_cnt == LP_TO_LAST) begin
            r_error <= 1'b1;
            r_state <= IDLE;
            r_ctl   <= ctl_for(IDLE);
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        ACF_STREAM: begin
          // iDurbinDone is deliberately not looked at until DURBIN.
          if (!bus.iAcfValid) begin
            r_cnt   <= '0;
            r_state <= DURBIN;
            r_ctl   <= ctl_for(DURBIN);
          end
        end
        DURBIN: begin
          if (bus.iDurbinDone) begin
            r_cnt   <= '0;
            r_state <= QUANT_DRAIN;
            r_ctl   <= ctl_for(QUANT_DRAIN);
          end else if (r_cnt == LP_TO_LAST) begin
            r_error <= 1'b1;
            r_state <= IDLE;
            r_ctl   <= ctl_for(IDLE);
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        QUANT_DRAIN: begin
          if (!bus.iQuantValid) begin
            r_cnt   <= '0;
            r_state <= FILTER;
            r_ctl   <= ctl_for(FILTER);
          end else if (r_cnt == LP_TO_LAST) begin
            r_error <= 1'b1;
            r_state <= IDLE;
            r_ctl   <= ctl_for(IDLE);
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        FILTER: begin
          if (r_cnt == LP_FLT_LAST) begin
            r_best       <= bus.iBestPredictor;
            r_best_valid <= 1'b1;
            r_state      <= RESULT;
            r_ctl        <= ctl_for(RESULT);
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        RESULT: begin
          r_state <= IDLE;
          r_ctl   <= ctl_for(IDLE);
        end
        default: begin
          r_state <= IDLE;
          r_ctl   <= ctl_for(IDLE);
        end
      endcase
    end
  end

endmodule
